// File: rtl/mux_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_scan                                                                 |
// | N-channel, W-bit registered multiplexer with manual select and           |
// | round-robin scan (programmable dwell). Optional: MUX_SCAN_SKIP_EN        |
// | restricts scanning to the channels enabled in ch_mask.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mux_scan #(
  parameter int N  = 4,
  parameter int W  = 7,
  parameter int DW = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [DW-1:0]   dwell,
  input  logic            hold,
  input  logic [N-1:0]    ch_mask,
  input  logic [N*W-1:0]  din,
  output logic [W-1:0]    dout,
  output logic [SELW-1:0] dout_ch,
  output logic            dout_vld,
  output logic            wrap
);

  localparam logic [SELW:0]   NUM_CH  = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST_CH = SELW'(N-1);

  logic [W-1:0]    dout_q, dout_d;
  logic [SELW-1:0] dout_ch_q, dout_ch_d;
  logic            dout_vld_q, dout_vld_d;
  logic            wrap_q, wrap_d;
  logic [DW-1:0]   cnt_q, cnt_d;

  logic [W-1:0]    ch_data [N];
  logic [DW-1:0]   eff_m1;
  logic            cur_ok;
  logic            cur_on;
  logic            mask_none;
  logic [SELW-1:0] base;
  logic [SELW-1:0] adv_ch;
  logic [SELW-1:0] nxt_ch;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign ch_data[g] = din[g*W +: W];
  end

  assign eff_m1 = (dwell == '0) ? '0 : dwell - DW'(1);
  assign cur_ok = {1'b0, dout_ch_q} < NUM_CH;
  // An out-of-range index (left over from manual mode) restarts scanning at 0.
  assign base   = (cur_ok && dout_ch_q != LAST_CH) ? dout_ch_q + SELW'(1) : '0;

`ifdef MUX_SCAN_SKIP_EN
  logic [SELW-1:0] idx;

  assign mask_none = ~|ch_mask;
  assign cur_on    = cur_ok ? ch_mask[dout_ch_q] : 1'b0;

  // Descending search so the first enabled channel after the current one wins.
  always_comb begin
    adv_ch = '0;
    idx    = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = SELW'((int'(base) + k) % N);
      if (ch_mask[idx]) adv_ch = idx;
    end
  end
`else
  logic unused_mask;

  assign unused_mask = ^ch_mask;
  assign mask_none   = 1'b0;
  assign cur_on      = cur_ok;
  assign adv_ch      = base;
`endif

  always_comb begin
    dout_d     = dout_q;
    dout_ch_d  = dout_ch_q;
    dout_vld_d = 1'b0;
    wrap_d     = 1'b0;
    cnt_d      = cnt_q;
    nxt_ch     = dout_ch_q;
    if (!hold) begin
      if (!mode) begin
        cnt_d     = '0;
        dout_ch_d = sel;
        if ({1'b0, sel} < NUM_CH) begin
          dout_d     = ch_data[sel];
          dout_vld_d = 1'b1;
        end else begin
          dout_d = '0;
        end
      end else if (mask_none) begin
        cnt_d  = '0;
        dout_d = '0;
      end else begin
        if (cur_on && cnt_q < eff_m1) begin
          cnt_d  = cnt_q + DW'(1);
          nxt_ch = dout_ch_q;
        end else begin
          cnt_d  = '0;
          nxt_ch = adv_ch;
          wrap_d = (adv_ch <= dout_ch_q);
        end
        dout_ch_d  = nxt_ch;
        dout_d     = ch_data[nxt_ch];
        dout_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q     <= '0;
      dout_ch_q  <= '0;
      dout_vld_q <= 1'b0;
      wrap_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      dout_q     <= dout_d;
      dout_ch_q  <= dout_ch_d;
      dout_vld_q <= dout_vld_d;
      wrap_q     <= wrap_d;
      cnt_q      <= cnt_d;
    end
  end

  assign dout     = dout_q;
  assign dout_ch  = dout_ch_q;
  assign dout_vld = dout_vld_q;
  assign wrap     = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// Testbench for mux_scan: directed scenarios plus random stimulus, all checked
// against a behavioural channel/dwell model.
module tb_mux_scan;

  localparam int N = 4, W = 7, DW = 8, SELW = 2;

  logic            clk = 1'b0;
  logic            rst, mode, hold;
  logic [SELW-1:0] sel;
  logic [DW-1:0]   dwell;
  logic [N-1:0]    ch_mask;
  logic [N*W-1:0]  din;
  logic [W-1:0]    dout;
  logic [SELW-1:0] dout_ch;
  logic            dout_vld, wrap;

  logic [1:0]      s_sel;
  logic [3*W-1:0]  s_din;
  logic [W-1:0]    s_dout;
  logic [1:0]      s_dout_ch;
  logic            s_dout_vld, s_wrap;

  int checks = 0;
  int failures = 0;

  int         m_ch, m_cnt, m_vld, m_wrap;
  logic [W-1:0] m_dout;

  always #5 clk = ~clk;

  mux_scan #(.N(N), .W(W), .DW(DW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .dwell(dwell), .hold(hold),
    .ch_mask(ch_mask), .din(din), .dout(dout), .dout_ch(dout_ch),
    .dout_vld(dout_vld), .wrap(wrap)
  );

  mux_scan #(.N(3), .W(W), .DW(DW)) dut3 (
    .clk(clk), .rst(rst), .mode(1'b0), .sel(s_sel), .dwell(8'd0), .hold(1'b0),
    .ch_mask(3'b111), .din(s_din), .dout(s_dout), .dout_ch(s_dout_ch),
    .dout_vld(s_dout_vld), .wrap(s_wrap)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit enabled(input int c);
`ifdef MUX_SCAN_SKIP_EN
    return ch_mask[c];
`else
    return 1'b1;
`endif
  endfunction

  // Next channel in modular order after cur that scanning may visit.
  function automatic int next_ch(input int cur);
    int start;
    start = (cur < N) ? cur + 1 : 0;
    for (int k = 0; k < N; k++)
      if (enabled((start + k) % N)) return (start + k) % N;
    return cur;
  endfunction

  function automatic logic [W-1:0] chan(input int c);
    return W'(din >> (c * W));
  endfunction

  task automatic model_step();
    int d, nc;
    if (rst) begin
      m_ch = 0; m_cnt = 0; m_dout = '0; m_vld = 0; m_wrap = 0;
    end else if (hold) begin
      m_vld = 0; m_wrap = 0;
    end else if (!mode) begin
      m_cnt = 0; m_ch = sel; m_wrap = 0;
      if (sel < N) begin m_dout = chan(sel); m_vld = 1; end
      else begin m_dout = '0; m_vld = 0; end
    end else if (ch_mask == '0 && next_ch(m_ch) == m_ch && !enabled(m_ch)) begin
      m_cnt = 0; m_dout = '0; m_vld = 0; m_wrap = 0;
    end else begin
      d = (dwell == 0) ? 1 : int'(dwell);
      if (m_ch < N && enabled(m_ch) && m_cnt < d - 1) begin
        m_cnt++; m_wrap = 0;
      end else begin
        nc = next_ch(m_ch);
        m_wrap = (nc <= m_ch) ? 1 : 0;
        m_ch = nc; m_cnt = 0;
      end
      m_dout = chan(m_ch); m_vld = 1;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, ".dout"},     32'(dout),     32'(m_dout));
    check({tag, ".dout_ch"},  32'(dout_ch),  32'(m_ch));
    check({tag, ".dout_vld"}, 32'(dout_vld), 32'(m_vld));
    check({tag, ".wrap"},     32'(wrap),     32'(m_wrap));
  endtask

  int exp_seq [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  initial begin
    rst = 1'b1; mode = 1'b0; hold = 1'b0; sel = '0; dwell = '0;
    ch_mask = '1; din = '0; s_sel = '0; s_din = '0;
    din[2*W +: W] = 7'h55;
    m_ch = 0; m_cnt = 0; m_dout = '0; m_vld = 0; m_wrap = 0;

    step("reset"); step("reset");
    check("reset.dout_const", 32'(dout), 32'd0);

    rst = 1'b0; sel = 2'd2;
    step("manual");
    check("manual.dout_55", 32'(dout), 32'h55);

    // Out-of-range select on the 3-channel instance.
    s_din = {7'h33, 7'h22, 7'h11};
    s_sel = 2'd3;
    @(posedge clk); #1;
    check("oor.dout", 32'(s_dout), 32'd0);
    check("oor.vld",  32'(s_dout_vld), 32'd0);
    check("oor.ch",   32'(s_dout_ch), 32'd3);
    s_sel = 2'd1;
    @(posedge clk); #1;
    check("sel1.dout", 32'(s_dout), 32'h22);
    check("sel1.vld",  32'(s_dout_vld), 32'd1);
    m_cnt = 0;
    model_step();

    // Scan order with dwell 3 after one manual cycle on channel 0.
    sel = 2'd0; din = {7'h44, 7'h33, 7'h22, 7'h11};
    step("pre_scan");
    mode = 1'b1; dwell = 8'd3;
    for (int i = 0; i < 12; i++) begin
      step("scan3");
      check("scan3.seq",  32'(dout_ch), 32'(exp_seq[i]));
      check("scan3.wrap", 32'(wrap), (i == 11) ? 32'd1 : 32'd0);
    end
    dwell = 8'd0;
    for (int i = 0; i < 6; i++) step("scan0");

    // Hold on the second cycle of channel 1.
    dwell = 8'd3;
    for (int i = 0; i < 30 && !(m_ch == 1 && m_cnt == 1); i++) step("to_hold");
    check("hold.reached", 32'(m_ch == 1 && m_cnt == 1), 32'd1);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("hold");
      check("hold.ch", 32'(dout_ch), 32'd1);
    end
    hold = 1'b0;
    step("release");
    check("release.ch1", 32'(dout_ch), 32'd1);
    step("release");
    check("release.ch2", 32'(dout_ch), 32'd2);

    // Reset with hold asserted while showing channel 2.
    hold = 1'b1; rst = 1'b1;
    step("rst_hold");
    check("rst_hold.vld", 32'(dout_vld), 32'd0);
    hold = 1'b0; rst = 1'b0;
    for (int i = 0; i < 4; i++) step("after_rst");

`ifdef MUX_SCAN_SKIP_EN
    rst = 1'b1; step("skip_rst");
    rst = 1'b0; ch_mask = 4'b1010; dwell = 8'd2;
    for (int i = 0; i < 9; i++) step("skip");
    ch_mask = 4'b0000;
    step("mask0");
    check("mask0.vld", 32'(dout_vld), 32'd0);
    ch_mask = 4'b0100;
    for (int i = 0; i < 6; i++) step("single");
`endif

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      hold  = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 5) mode = ~mode;
      sel   = SELW'($urandom);
      if ($urandom_range(0, 99) < 10) dwell = DW'($urandom_range(0, 4));
`ifdef MUX_SCAN_SKIP_EN
      if ($urandom_range(0, 99) < 5) ch_mask = N'($urandom);
`endif
      din   = {N{7'h0}} | (N*W)'({$urandom, $urandom});
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_scan.md
# mux_scan

Parametrised N-channel, W-bit registered multiplexer with manual select and automatic round-robin scan mode. Each channel is presented on the output for a programmable dwell time, with channel index, valid and wrap indications. It sits between the top-level dedicated/bidirectional input pins and the output pins, and generalises the earlier fixed 7-bit two-way selector.

## Interface

**Parameters**
- `N`, 4: number of input channels, ≥2.
- `W`, 7: channel data width, ≥1.
- `DW`, 8: dwell counter width.
- `SELW` (localparam): `$clog2(N)`, derived.

**Ports**
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `mode`  in  1  0 = manual, 1 = scan.
- `sel`  in  SELW  manual channel select.
- `dwell`  in  DW  cycles per channel in scan mode. 0 is treated as 1.
- `hold`  in  1  freeze all state and outputs.
- `ch_mask`  in  N  per-channel scan enable. Used only with `MUX_SCAN_SKIP_EN`, otherwise ignored.
- `din`  in  N*W  channel k occupies bits `[k*W +: W]`.
- `dout`  out  W  registered selected data.
- `dout_ch`  out  SELW  index of the channel currently on `dout`.
- `dout_vld`  out  1  `dout` holds valid channel data.
- `wrap`  out  1  one-cycle pulse when scan returns to the lowest channel.

## Operation

- **Reset** (`rst`=1 at an edge): `dout`=0, `dout_ch`=0, `dout_vld`=0, `wrap`=0, dwell counter `cnt`=0. Reset overrides `hold` and all other inputs, including mid-dwell.
- **Per-edge update.** When not in reset and `hold`=0, compute `nxt_ch`, then register:
  - `dout_ch` <= `nxt_ch`
  - `dout` <= `din[nxt_ch]`
- **Manual mode** (`mode`=0):
  - `nxt_ch` = `sel`, and `cnt` <= 0.
  - If `sel` ≥ N: `dout` <= 0, `dout_vld` <= 0, and `dout_ch` <= `sel`.
  - Otherwise `dout_vld` <= 1.
- **Scan mode** (`mode`=1):
  - Effective dwell `D` = max(`dwell`, 1).
  - If `cnt` < D-1: `cnt`++ and `nxt_ch` = `dout_ch`.
  - Otherwise `cnt` <= 0 and `nxt_ch` = the next channel, wrapping N-1 → 0.
  - `dout` keeps resampling `din` of the current channel every cycle, so live data changes are visible within a dwell.
  - If `dout_ch` is out of range when scan starts, the next channel is 0.
  - `dout_vld` <= 1.
- **Wrap pulse.** `wrap` <= 1 only on the edge where scan advances and the new index is ≤ the old index. Otherwise `wrap` <= 0.
- **Mode switch.**
  - Manual→scan: scanning starts from the current `dout_ch` with `cnt`=0, so it receives a full dwell.
  - Scan→manual: `sel` is taken on the next edge.
- **Dwell change mid-scan.** `dwell` is re-read every cycle. If `cnt` is already ≥ new D-1, the channel advances on the next edge.
- **Hold** (`hold`=1, no reset):
  - `dout`, `dout_ch`, `cnt` and the channel state are frozen.
  - `dout_vld` <= 0 and `wrap` <= 0.
  - On release, operation resumes with the frozen `cnt`.

## Timing

- One-cycle latency: `sel`/`din` sampled at edge t appear on `dout` after edge t.
- In scan mode with dwell D, each channel is shown for exactly D consecutive cycles.
- A full scan period is N·D cycles, with one `wrap` pulse per period.
- All outputs are registered. There are no combinational input→output paths.

## Configuration

- **`MUX_SCAN_SKIP_EN` defined:** scan advances to the next channel, in modular order, whose `ch_mask` bit is 1.
  - `wrap` fires when the new index is ≤ the old index.
  - If exactly one bit is set: the scan stays on that channel, and `wrap` pulses every D cycles.
  - If `ch_mask` is all zero: `dout_ch` is held, `dout` <= 0, `dout_vld` <= 0, and `cnt` <= 0.
  - If the current channel is masked while dwelling, it advances on the next edge.
  - Manual mode ignores `ch_mask`.
- **Not defined:** `ch_mask` is unused and every channel is visited in order.

## Test plan

- **Reset and manual select:** `rst`=1 for 2 cycles with `din` ch2=7'h55 → all outputs 0. Release with `mode`=0, `sel`=2 → one cycle later `dout`=7'h55, `dout_ch`=2, `dout_vld`=1.
- **Out-of-range select:** N=3, `sel`=3 → `dout`=0, `dout_vld`=0, `dout_ch`=3.
- **Scan order and wrap:** N=4, `dwell`=3 → `dout_ch` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. `wrap`=1 only on the cycle `dout_ch` returns to 0. Repeat with `dwell`=0 → channel changes every cycle.
- **Hold mid-dwell:** hold on the second cycle of ch1 for 5 cycles → `dout`/`dout_ch` unchanged and `dout_vld`=0. After release, ch1 shows for exactly 1 more cycle.
- **Reset mid-scan:** `rst` asserted with `hold`=1 at ch2 → the next cycle shows all outputs 0, and `cnt` restarts.
- **`MUX_SCAN_SKIP_EN`:**
  - `ch_mask`=4'b1010, `dwell`=2 → sequence 1,1,3,3,1,…, with `wrap` on the 3→1 transitions.
  - `ch_mask`=0 → `dout_vld`=0, `dout`=0.
